video_timing_gen: RTL

Parametrised multi-mode HDMI/DVI video timing generator and pixel aligner, the successor of the fixed 640x480 HDMI display driver. It produces sync/DE timing for four runtime-selectable VESA modes. It issues pixel requests to the read-port FIFO a configurable number of cycles ahead of DE, to cover FIFO read latency. It optionally replaces FIFO data with an internal colour-bar pattern. It sits between the SDRAM read-port FIFO and the TMDS encoder/serialiser.

---
 rtl/video_timing_pkg.sv | 23 ++
 rtl/vtg_pattern_gen.sv | 32 +++
 rtl/video_timing_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: VESA mode table, colour-bar constants and pixel-width helper
// shared by the video timing generator and its pattern source.
package video_timing_pkg;
  localparam int DEF_COMP_W = 8;
  localparam int MODE_W = 12;
  typedef struct packed {
    logic [MODE_W-1:0] h_act, h_fp, h_sync, h_bp;
    logic [MODE_W-1:0] v_act, v_fp, v_sync, v_bp;
    logic pos;
    logic [MODE_W-1:0] bar_w;
  } mode_t;
  localparam mode_t MODE_TABLE [4] = '{
    '{12'd640,  12'd16,  12'd96,  12'd48,  12'd480, 12'd10, 12'd2, 12'd33, 1'b0, 12'd80},
    '{12'd800,  12'd40,  12'd128, 12'd88,  12'd600, 12'd1,  12'd4, 12'd23, 1'b1, 12'd100},
    '{12'd1280, 12'd110, 12'd40,  12'd220, 12'd720, 12'd5,  12'd5, 12'd20, 1'b1, 12'd160},
    '{12'd1024, 12'd24,  12'd136, 12'd160, 12'd768, 12'd3,  12'd6, 12'd29, 1'b0, 12'd128}
  };
  // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
  function automatic int pix_w(int comp_w);
    return 3 * comp_w;
  endfunction
endpackage

// File: rtl/vtg_pattern_gen.sv
// vtg_pattern_gen: colour-bar source; the bar colour for xpos_i in mode_i
// appears on rgb_o LAT+1 cycles later.
module vtg_pattern_gen import video_timing_pkg::*; #(
  parameter int COMP_W = DEF_COMP_W,
  parameter int CNT_W = 12,
  parameter int LAT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic [CNT_W-1:0] xpos_i,
  input  logic [1:0] mode_i,
  output logic [pix_w(COMP_W)-1:0] rgb_o
);
  logic [CNT_W-1:0] bar_w;
  logic [2:0] idx;
  logic [2:0] c;
  logic [pix_w(COMP_W)-1:0] rgb_d;
  logic [pix_w(COMP_W)-1:0] rgb_q [LAT+1];
  // bar index by threshold compare instead of a divider
  always_comb begin
    bar_w = CNT_W'(MODE_TABLE[mode_i].bar_w);
    idx = '0;
    for (int k = 1; k < 8; k++) idx = xpos_i >= CNT_W'(k) * bar_w ? 3'(k) : idx;
    c = BAR_RGB[idx];
    rgb_d = {{COMP_W{c[2]}}, {COMP_W{c[1]}}, {COMP_W{c[0]}}};
  end
  always_ff @(posedge clk_i) begin
    rgb_q[0] <= rst_ni ? rgb_d : '0;
    for (int k = 1; k <= LAT; k++) rgb_q[k] <= rst_ni ? rgb_q[k-1] : '0;
  end
  assign rgb_o = rgb_q[LAT];
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: multi-mode sync/DE timing with early FIFO requests and
// latency-matched pixel alignment, optional colour-bar substitution.
module video_timing_gen import video_timing_pkg::*; #(
  parameter int COMP_W = DEF_COMP_W,
  parameter int REQ_LEAD = 1,
  parameter int DEFAULT_MODE = 0,
  parameter int CNT_W = 12
) (
  input  logic pixel_clk,
  input  logic sys_rst_n,
  input  logic [1:0] mode_sel,
  input  logic pattern_en,
  input  logic [pix_w(COMP_W)-1:0] pixel_data,
  output logic data_req,
  output logic [CNT_W-1:0] pixel_xpos,
  output logic [CNT_W-1:0] pixel_ypos,
  output logic video_hs,
  output logic video_vs,
  output logic video_de,
  output logic [pix_w(COMP_W)-1:0] video_rgb,
  output logic frame_start,
  output logic [1:0] cur_mode
);
  localparam int PW = pix_w(COMP_W);
  localparam int D = REQ_LEAD + 1;
  localparam logic IDLE_LVL = ~MODE_TABLE[DEFAULT_MODE].pos;
  logic [1:0] mode_q, mode_d;
  logic pat_q, pat_d, pos;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d, x_d, y_d, x_q, y_q;
  logic [CNT_W-1:0] h_sync, h_st, h_end, h_tot, v_sync, v_st, v_end, v_tot;
  logic h_last, v_last, act, hs_d, vs_d, fs_d;
  logic req_q, fs_q, hs_q, vs_q;
  logic [D-1:0] hs_sr_q, vs_sr_q, de_sr_q;
  logic [D:0] hs_v, vs_v, de_v;
  logic [PW-1:0] bar, rgb_d, rgb_q;
  always_comb begin
    h_sync = CNT_W'(MODE_TABLE[mode_q].h_sync);
    h_st = h_sync + CNT_W'(MODE_TABLE[mode_q].h_bp);
    h_end = h_st + CNT_W'(MODE_TABLE[mode_q].h_act);
    h_tot = h_end + CNT_W'(MODE_TABLE[mode_q].h_fp);
    v_sync = CNT_W'(MODE_TABLE[mode_q].v_sync);
    v_st = v_sync + CNT_W'(MODE_TABLE[mode_q].v_bp);
    v_end = v_st + CNT_W'(MODE_TABLE[mode_q].v_act);
    v_tot = v_end + CNT_W'(MODE_TABLE[mode_q].v_fp);
    pos = MODE_TABLE[mode_q].pos;
    h_last = h_q == h_tot - CNT_W'(1);
    v_last = v_q == v_tot - CNT_W'(1);
    h_d = h_last ? '0 : h_q + CNT_W'(1);
    v_d = !h_last ? v_q : v_last ? '0 : v_q + CNT_W'(1);
    act = h_q >= h_st && h_q < h_end && v_q >= v_st && v_q < v_end;
    x_d = act ? h_q - h_st : '0;
    y_d = act ? v_q - v_st : '0;
    fs_d = act && x_d == '0 && y_d == '0;
    hs_d = h_q < h_sync ? pos : ~pos;
    vs_d = v_q < v_sync ? pos : ~pos;
    mode_d = h_last && v_last ? mode_sel : mode_q;
    pat_d = h_last && v_last ? pattern_en : pat_q;
    hs_v = {hs_sr_q, hs_q};
    vs_v = {vs_sr_q, vs_q};
    de_v = {de_sr_q, req_q};
    rgb_d = !de_v[REQ_LEAD] ? '0 : pat_q ? bar : pixel_data;
  end
  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      h_q <= '0;
      v_q <= '0;
      mode_q <= 2'(DEFAULT_MODE);
      pat_q <= 1'b0;
      req_q <= 1'b0;
      fs_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      hs_q <= IDLE_LVL;
      vs_q <= IDLE_LVL;
      hs_sr_q <= {D{IDLE_LVL}};
      vs_sr_q <= {D{IDLE_LVL}};
      de_sr_q <= '0;
      rgb_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      mode_q <= mode_d;
      pat_q <= pat_d;
      req_q <= act;
      fs_q <= fs_d;
      x_q <= x_d;
      y_q <= y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      hs_sr_q <= hs_v[D-1:0];
      vs_sr_q <= vs_v[D-1:0];
      de_sr_q <= de_v[D-1:0];
      rgb_q <= rgb_d;
    end
  end
  // fed from the pre-register position so the bar lands with the pixel_data sample
  vtg_pattern_gen #(.COMP_W(COMP_W), .CNT_W(CNT_W), .LAT(REQ_LEAD)) u_pat (
    .clk_i(pixel_clk),
    .rst_ni(sys_rst_n),
    .xpos_i(x_d),
    .mode_i(mode_q),
    .rgb_o(bar)
  );
  assign data_req = req_q;
  assign pixel_xpos = x_q;
  assign pixel_ypos = y_q;
  assign frame_start = fs_q;
  assign video_hs = hs_v[D];
  assign video_vs = vs_v[D];
  assign video_de = de_v[D];
  assign video_rgb = rgb_q;
  assign cur_mode = mode_q;
endmodule
